// File: rtl/dist22_fifo2.sv
// Two-entry FIFO with registered head output; dout holds its last value when empty.
// Pushes while full and pops while empty are ignored.
module dist22_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  logic [WIDTH-1:0] head_q, tail_q;
  logic [1:0]       occ_q;
  logic             do_push, do_pop;

  assign valid   = (occ_q != 2'd0);
  assign full    = (occ_q == 2'd2);
  assign dout    = head_q;
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= din;
          else               tail_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          // Promote the tail; with one entry the head keeps its stale value.
          if (occ_q == 2'd2) head_q <= tail_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry, since push is blocked when full.
          head_q <= din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dist22_stream.sv
// Registered 1-to-2 stream distributor: each accepted word goes to one of two
// independent 2-entry buffers, and each output counts its deliveries.
module dist22_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 8
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Q1,
  output logic             Q1_VALID,
  input  logic             Q1_READY,
  output logic [WIDTH-1:0] Q2,
  output logic             Q2_VALID,
  input  logic             Q2_READY,
  output logic [CNTW-1:0]  CNT1,
  output logic [CNTW-1:0]  CNT2
);

  logic full1, full2;
  logic push1, push2, pop1, pop2;
  logic [CNTW-1:0] cnt1_q, cnt2_q;

  // Depends only on occupancy flops and IN_SEL, never on the consumer readies.
  assign IN_READY = IN_SEL ? !full2 : !full1;
  assign push1    = IN_VALID && IN_READY && !IN_SEL;
  assign push2    = IN_VALID && IN_READY && IN_SEL;
  assign pop1     = Q1_VALID && Q1_READY;
  assign pop2     = Q2_VALID && Q2_READY;

  dist22_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .CLK   (CLK),
    .RSTB  (RSTB),
    .push  (push1),
    .pop   (pop1),
    .din   (IN),
    .dout  (Q1),
    .valid (Q1_VALID),
    .full  (full1)
  );

  dist22_fifo2 #(.WIDTH(WIDTH)) u_fifo2 (
    .CLK   (CLK),
    .RSTB  (RSTB),
    .push  (push2),
    .pop   (pop2),
    .din   (IN),
    .dout  (Q2),
    .valid (Q2_VALID),
    .full  (full2)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      if (pop1) cnt1_q <= cnt1_q + 1'b1;
      if (pop2) cnt2_q <= cnt2_q + 1'b1;
    end
  end

  assign CNT1 = cnt1_q;
  assign CNT2 = cnt2_q;

endmodule

// File: tb/tb_dist22_stream.sv
// Directed bench for dist22_stream: main instance with defaults plus a CNTW=2
// instance for counter wrap.
module tb_dist22_stream;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [7:0] in_d = '0;
  logic       in_sel = 1'b0, in_valid = 1'b0, in_ready;
  logic [7:0] q1, q2;
  logic       q1_valid, q2_valid;
  logic       q1_ready = 1'b0, q2_ready = 1'b0;
  logic [7:0] cnt1, cnt2;

  logic [7:0] b_in = '0;
  logic       b_sel = 1'b0, b_valid = 1'b0, b_ready;
  logic [7:0] b_q1, b_q2;
  logic       b_q1_valid, b_q2_valid;
  logic       b_q2_ready = 1'b0;
  logic [1:0] b_cnt1, b_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dist22_stream #(.WIDTH(8), .CNTW(8)) u_dut (
    .CLK      (clk),
    .RSTB     (rstb),
    .IN       (in_d),
    .IN_SEL   (in_sel),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .Q1       (q1),
    .Q1_VALID (q1_valid),
    .Q1_READY (q1_ready),
    .Q2       (q2),
    .Q2_VALID (q2_valid),
    .Q2_READY (q2_ready),
    .CNT1     (cnt1),
    .CNT2     (cnt2)
  );

  dist22_stream #(.WIDTH(8), .CNTW(2)) u_dut_w2 (
    .CLK      (clk),
    .RSTB     (rstb),
    .IN       (b_in),
    .IN_SEL   (b_sel),
    .IN_VALID (b_valid),
    .IN_READY (b_ready),
    .Q1       (b_q1),
    .Q1_VALID (b_q1_valid),
    .Q1_READY (1'b0),
    .Q2       (b_q2),
    .Q2_VALID (b_q2_valid),
    .Q2_READY (b_q2_ready),
    .CNT1     (b_cnt1),
    .CNT2     (b_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; q1_ready = 1'b0; q2_ready = 1'b0;
    b_valid = 1'b0; b_q2_ready = 1'b0;
    rstb = 1'b0;
    #2;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  initial begin
    logic [7:0] words [6];
    logic [1:0] wrap_exp [5];
    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset values while RSTB is held low.
    #3;
    check("rst_q1_valid", q1_valid, 1'b0);
    check("rst_q2_valid", q2_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cnt1", cnt1, 8'h00);
    check("rst_q1", q1, 8'h00);
    @(negedge clk);
    rstb = 1'b1;

    // Single word to Q1, visible one cycle later.
    in_d = 8'hA5; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_q1_valid", q1_valid, 1'b1);
    check("t1_q1", q1, 8'hA5);
    check("t1_q2_valid", q2_valid, 1'b0);
    check("t1_cnt1", cnt1, 8'h00);

    // Fill Q1; input stalls only for SEL=0.
    do_reset();
    in_sel = 1'b0; in_valid = 1'b1; in_d = 8'h11;
    tick();
    in_d = 8'h22;
    tick();
    in_valid = 1'b0;
    #1 check("full_ready_sel0", in_ready, 1'b0);
    in_sel = 1'b1;
    #1 check("full_ready_sel1", in_ready, 1'b1);
    in_d = 8'h33; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("q2_after_push", q2, 8'h33);
    check("q2_valid_after_push", q2_valid, 1'b1);
    check("q1_head_held", q1, 8'h11);

    // Pop from full Q1 while offering a word: not accepted this cycle.
    q1_ready = 1'b1; in_sel = 1'b0; in_d = 8'h44; in_valid = 1'b1;
    #1 check("pop_full_ready_same_cycle", in_ready, 1'b0);
    tick();
    q1_ready = 1'b0; in_valid = 1'b0;
    check("pop_full_q1", q1, 8'h22);
    check("pop_full_cnt1", cnt1, 8'h01);
    check("pop_full_ready_next", in_ready, 1'b1);
    check("pop_full_q1_valid", q1_valid, 1'b1);
    tick();
    check("pop_full_no_accept_q1", q1, 8'h22);

    // Alternating stream with both consumers ready.
    do_reset();
    q1_ready = 1'b1; q2_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_d = words[i]; in_sel = i[0]; in_valid = 1'b1;
      #1 check($sformatf("stream_ready_%0d", i), in_ready, 1'b1);
      tick();
      if (i[0]) begin
        check($sformatf("stream_q2_%0d", i), q2, words[i]);
        check($sformatf("stream_q2v_%0d", i), q2_valid, 1'b1);
      end else begin
        check($sformatf("stream_q1_%0d", i), q1, words[i]);
        check($sformatf("stream_q1v_%0d", i), q1_valid, 1'b1);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("stream_cnt1", cnt1, 8'd3);
    check("stream_cnt2", cnt2, 8'd3);
    check("stream_q1v_end", q1_valid, 1'b0);
    check("stream_q2v_end", q2_valid, 1'b0);

    // Counter wrap on the CNTW=2 instance.
    do_reset();
    b_sel = 1'b1; b_q2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in = 8'h50 + 8'(i); b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      check($sformatf("wrap_q2_%0d", i), b_q2, 8'h50 + 8'(i));
      tick();
      check($sformatf("wrap_cnt2_%0d", i), b_cnt2, wrap_exp[i]);
    end

    // Reset mid-transfer with both buffers full.
    do_reset();
    in_valid = 1'b1; in_sel = 1'b0; in_d = 8'hA1;
    tick();
    in_d = 8'hA2;
    tick();
    in_sel = 1'b1; in_d = 8'hB1;
    tick();
    in_d = 8'hB2;
    tick();
    in_valid = 1'b0; in_sel = 1'b0;
    check("pre_rst_ready", in_ready, 1'b0);
    q1_ready = 1'b1; q2_ready = 1'b1;
    tick();
    check("pre_rst_cnt1", cnt1, 8'd1);
    #2 rstb = 1'b0;
    #1;
    check("midrst_q1_valid", q1_valid, 1'b0);
    check("midrst_q2_valid", q2_valid, 1'b0);
    check("midrst_cnt1", cnt1, 8'h00);
    check("midrst_cnt2", cnt2, 8'h00);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_q2", q2, 8'h00);
    @(negedge clk);
    rstb = 1'b1;
    q1_ready = 1'b0; q2_ready = 1'b0;
    in_d = 8'h77; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_q1_valid", q1_valid, 1'b1);
    check("post_rst_q1", q1, 8'h77);
    check("post_rst_q2_valid", q2_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
